// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO plus registered issue stage in front of the ALU.
// Ports: producer valid/ready {op,a,b}, flush, registered ALU operands/opcode/valid,
//        consumer alu_ready, occupancy level and 16-bit issued-command counter.
module alu_cmd_queue #(
    parameter int WIDTH  = 8,
    parameter int OPCODE = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPCODE-1:0]          in_op,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       flush,
    output logic [WIDTH-1:0]           alu_data_in1,
    output logic [WIDTH-1:0]           alu_data_in2,
    output logic [OPCODE-1:0]          alu_op_code,
    output logic                       alu_valid_data,
    input  logic                       alu_ready,
    output logic [$clog2(DEPTH+1):0]   level,
    output logic [15:0]                issue_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = OPCODE + 2 * WIDTH;
    localparam int LVW = $clog2(DEPTH+1) + 1;

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_mem [DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [CW-1:0]   r_out;
    logic [15:0]     r_issue;

    logic [AW:0]     w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_load_head;
    logic            w_load_in;
    logic            w_clear;
    logic            w_fifo_wr;
    logic [CW-1:0]   w_in_cmd;

    // Wrap bit in the pointers distinguishes full from empty.
    assign w_count  = r_wptr - r_rptr;
    assign w_full   = (w_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_wptr == r_rptr);
    assign w_in_cmd = {in_op, in_a, in_b};

    assign in_ready       = !w_full;
    assign alu_valid_data = (r_state == S_HOLD);
    assign w_push         = in_valid && in_ready;
    assign w_pop          = alu_valid_data && alu_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output register refills from the FIFO head first; the input is only
    // bypassed when the FIFO is empty, which keeps strict ordering.
    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        w_load_in   = 1'b0;
        w_clear     = 1'b0;
        w_fifo_wr   = 1'b0;
        unique case (r_state)
            S_EMPTY: begin
                if (!w_empty) begin
                    w_load_head = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (w_push) begin
                    w_load_in   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_pop) begin
                    if (!w_empty) begin
                        w_load_head = 1'b1;
                    end else if (w_push) begin
                        w_load_in = 1'b1;
                    end else begin
                        w_clear     = 1'b1;
                        w_state_nxt = S_EMPTY;
                    end
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        w_fifo_wr = w_push && !w_load_in;
        // Flush discards any push/pop in the same cycle.
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_load_head = 1'b0;
            w_load_in   = 1'b0;
            w_clear     = 1'b1;
            w_fifo_wr   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wptr[AW-1:0]] <= w_in_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_load_head) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_load_head) begin
            r_out <= r_mem[r_rptr[AW-1:0]];
        end else if (w_load_in) begin
            r_out <= w_in_cmd;
        end else if (w_clear) begin
            r_out <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue <= '0;
        end else if (w_pop && !flush) begin
            r_issue <= r_issue + 16'd1;
        end
    end

    assign {alu_op_code, alu_data_in1, alu_data_in2} = r_out;
    assign level     = LVW'(w_count) + LVW'(alu_valid_data);
    assign issue_cnt = r_issue;

endmodule
